// File: rtl/gate_window_ctrl_pkg.sv
// Shared types and default sizing for the clock-enable window generator.
package gate_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } gate_state_e;

   localparam int CNT_W_DEF = 30;

   // Short defaults keep simulation runs fast; silicon runs a 1 s period with a 10 ms window.
`ifdef SIMULATION
   localparam int DEF_PERIOD_DEF = 1_000 - 1;
   localparam int DEF_ON_DEF     = 10 - 1;
`else
   localparam int DEF_PERIOD_DEF = 100_000_000 - 1;
   localparam int DEF_ON_DEF     = 1_000_000 - 1;
`endif

endpackage

// File: rtl/gate_window_ctrl_if.sv
// Configuration port: valid/ready request carrying period, window and mode, plus reject pulse.
interface gate_window_ctrl_if
   import gate_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) ();
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_on;
   logic             cfg_oneshot;
   logic             err_cfg;

   modport master (
      output cfg_valid, cfg_period, cfg_on, cfg_oneshot,
      input  cfg_ready, err_cfg
   );

   modport slave (
      input  cfg_valid, cfg_period, cfg_on, cfg_oneshot,
      output cfg_ready, err_cfg
   );
endinterface

// File: rtl/gate_cfg_shadow.sv
// Config handshake, range check, shadow and active registers. A request accepted while
// running waits in the shadow until the FSM signals a period boundary via apply_i.
module gate_cfg_shadow
   import gate_ctrl_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEF_PERIOD = DEF_PERIOD_DEF,
   parameter int DEF_ON     = DEF_ON_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             idle_i,
   input  logic             apply_i,
   gate_window_ctrl_if.slave cfg,
   output logic [CNT_W-1:0] act_period_o,
   output logic [CNT_W-1:0] act_on_o,
   output logic             act_oneshot_o,
   output logic [CNT_W-1:0] act_period_nxt_o
);

   logic [CNT_W-1:0] act_period_q, act_period_d;
   logic [CNT_W-1:0] act_on_q, act_on_d;
   logic             act_oneshot_q, act_oneshot_d;
   logic [CNT_W-1:0] shd_period_q, shd_period_d;
   logic [CNT_W-1:0] shd_on_q, shd_on_d;
   logic             shd_oneshot_q, shd_oneshot_d;
   logic             pend_q, pend_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic             hs;
   logic             bad;

   // Accept, reject, shadow or load directly; promote the shadow on apply.
   always_comb begin
      act_period_d  = act_period_q;
      act_on_d      = act_on_q;
      act_oneshot_d = act_oneshot_q;
      shd_period_d  = shd_period_q;
      shd_on_d      = shd_on_q;
      shd_oneshot_d = shd_oneshot_q;
      pend_d        = pend_q;
      ready_d       = ready_q;
      hs            = cfg.cfg_valid && ready_q;
      bad           = cfg.cfg_on > cfg.cfg_period;
      err_d         = hs && bad;
      if (pend_q && apply_i) begin
         act_period_d  = shd_period_q;
         act_on_d      = shd_on_q;
         act_oneshot_d = shd_oneshot_q;
         pend_d        = 1'b0;
         ready_d       = 1'b1;
      end
      // ready_q=1 implies pend_q=0, so this never collides with the promotion above.
      if (hs && !bad) begin
         if (idle_i) begin
            act_period_d  = cfg.cfg_period;
            act_on_d      = cfg.cfg_on;
            act_oneshot_d = cfg.cfg_oneshot;
         end else begin
            shd_period_d  = cfg.cfg_period;
            shd_on_d      = cfg.cfg_on;
            shd_oneshot_d = cfg.cfg_oneshot;
            pend_d        = 1'b1;
            ready_d       = 1'b0;
         end
      end
   end

   // Register file state; reset drops any pending shadow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_period_q  <= CNT_W'(DEF_PERIOD);
         act_on_q      <= CNT_W'(DEF_ON);
         act_oneshot_q <= 1'b0;
         shd_period_q  <= '0;
         shd_on_q      <= '0;
         shd_oneshot_q <= 1'b0;
         pend_q        <= 1'b0;
         ready_q       <= 1'b1;
         err_q         <= 1'b0;
      end else begin
         act_period_q  <= act_period_d;
         act_on_q      <= act_on_d;
         act_oneshot_q <= act_oneshot_d;
         shd_period_q  <= shd_period_d;
         shd_on_q      <= shd_on_d;
         shd_oneshot_q <= shd_oneshot_d;
         pend_q        <= pend_d;
         ready_q       <= ready_d;
         err_q         <= err_d;
      end
   end

   assign cfg.cfg_ready     = ready_q;
   assign cfg.err_cfg       = err_q;
   assign act_period_o      = act_period_q;
   assign act_on_o          = act_on_q;
   assign act_oneshot_o     = act_oneshot_q;
   assign act_period_nxt_o  = act_period_d;

endmodule

// File: rtl/gate_window_ctrl.sv
// Clock-enable window generator feeding a BUFGCE CE pin: ce high for (on+1) of every
// (period+1) clk cycles, all outputs taken directly from flops.
//
//  state | meaning
//  IDLE  | stopped, cnt held at 0, ce low
//  ON    | enable window active, ce high
//  OFF   | remainder of period, ce low
module gate_window_ctrl
   import gate_ctrl_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEF_PERIOD = DEF_PERIOD_DEF,
   parameter int DEF_ON     = DEF_ON_DEF
) (
   input  logic clk,
   input  logic rst_n,
   gate_window_ctrl_if.slave cfg,
   input  logic start,
   input  logic stop,
   output logic ce,
   output logic busy,
   output logic period_tick
);

   gate_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stop_pend_q, stop_pend_d;
   logic             ce_q, busy_q, tick_q;
   logic [CNT_W-1:0] act_period, act_on, act_period_nxt;
   logic             act_oneshot;
   logic             wrap, at_on, stop_eff, apply;

   assign wrap     = cnt_q == act_period;
   assign at_on    = cnt_q == act_on;
   assign stop_eff = stop_pend_q | stop;
   // Shadow may promote at every period wrap, and also once stopped so it never strands.
   assign apply    = (state_q == IDLE) || wrap;

   gate_cfg_shadow #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_ON     (DEF_ON)
   ) u_shadow (
      .clk              (clk),
      .rst_n            (rst_n),
      .idle_i           (state_q == IDLE),
      .apply_i          (apply),
      .cfg              (cfg),
      .act_period_o     (act_period),
      .act_on_o         (act_on),
      .act_oneshot_o    (act_oneshot),
      .act_period_nxt_o (act_period_nxt)
   );

   // Next state, counter and stop-pending; a stop in ON lets the window finish.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stop_pend_d = stop_pend_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start && !stop) state_d = ON;
         end
         ON: begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (stop) stop_pend_d = 1'b1;
            if (at_on) begin
               if (wrap) begin
                  if (act_oneshot || stop_eff) state_d = IDLE;
               end else if (stop_eff) begin
                  state_d = IDLE;
               end else begin
                  state_d = OFF;
               end
            end
         end
         OFF: begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (stop)                    state_d = IDLE;
            else if (wrap && act_oneshot) state_d = IDLE;
            else if (wrap)                state_d = ON;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) begin
         cnt_d       = '0;
         stop_pend_d = 1'b0;
      end
   end

   // State, counter and registered outputs derived from next-state values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         ce_q        <= 1'b0;
         busy_q      <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         ce_q        <= state_d == ON;
         busy_q      <= state_d != IDLE;
         tick_q      <= (state_d != IDLE) && (cnt_d == act_period_nxt);
      end
   end

   assign ce          = ce_q;
   assign busy        = busy_q;
   assign period_tick = tick_q;

endmodule

// File: tb/tb_gate_window_ctrl.sv
// Directed bench for gate_window_ctrl with hand-derived ce/tick/busy patterns.
module tb_gate_window_ctrl;
   localparam int CNT_W = 30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic ce, busy, period_tick;
   int   n_chk = 0;
   int   n_fail = 0;

   gate_window_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

   gate_window_ctrl #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (999),
      .DEF_ON     (9)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg         (cfg_if),
      .start       (start),
      .stop        (stop),
      .ce          (ce),
      .busy        (busy),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic write_cfg(input int per, input int on, input logic os);
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_period  = CNT_W'(per);
      cfg_if.cfg_on      = CNT_W'(on);
      cfg_if.cfg_oneshot = os;
      step();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if (ce !== 1'b0 || busy !== 1'b0 || period_tick !== 1'b0 ||
          cfg_if.err_cfg !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset: ce=%b busy=%b tick=%b err=%b ready=%b expected 0 0 0 0 1",
                  ce, busy, period_tick, cfg_if.err_cfg, cfg_if.cfg_ready);
      end
   endtask

   task automatic test_default_run();
      logic exp_ce, exp_tick;
      do_reset();
      pulse_start();
      for (int i = 0; i <= 1001; i++) begin
         exp_ce   = (i < 10) || (i >= 1000);
         exp_tick = (i == 999);
         n_chk++;
         if (ce !== exp_ce || period_tick !== exp_tick || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL default_run cyc %0d: ce=%b tick=%b busy=%b expected %b %b 1",
                     i, ce, period_tick, busy, exp_ce, exp_tick);
         end
         step();
      end
   endtask

   task automatic test_cfg_idle();
      logic exp_ce, exp_tick;
      do_reset();
      write_cfg(19, 4, 1'b0);
      n_chk++;
      if (cfg_if.err_cfg !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_idle accept: err=%b ready=%b expected 0 1", cfg_if.err_cfg, cfg_if.cfg_ready);
      end
      pulse_start();
      for (int i = 0; i < 60; i++) begin
         exp_ce   = (i % 20) < 5;
         exp_tick = (i % 20) == 19;
         n_chk++;
         if (ce !== exp_ce || period_tick !== exp_tick) begin
            n_fail++;
            $display("FAIL cfg_idle cyc %0d: ce=%b tick=%b expected %b %b",
                     i, ce, period_tick, exp_ce, exp_tick);
         end
         step();
      end
   endtask

   task automatic test_cfg_reject();
      do_reset();
      write_cfg(4, 9, 1'b0);
      n_chk++;
      if (cfg_if.err_cfg !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reject pulse: err=%b ready=%b expected 1 1", cfg_if.err_cfg, cfg_if.cfg_ready);
      end
      step();
      n_chk++;
      if (cfg_if.err_cfg !== 1'b0) begin
         n_fail++;
         $display("FAIL reject pulse width: err=%b expected 0", cfg_if.err_cfg);
      end
      pulse_start();
      for (int i = 0; i < 14; i++) begin
         n_chk++;
         if (ce !== (i < 10) || period_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reject keeps defaults cyc %0d: ce=%b tick=%b expected %b 0",
                     i, ce, period_tick, (i < 10));
         end
         step();
      end
   endtask

   task automatic test_shadow();
      logic exp_ce, exp_tick, exp_rdy;
      do_reset();
      write_cfg(19, 4, 1'b0);
      pulse_start();
      for (int i = 0; i <= 40; i++) begin
         if (i < 20) begin
            exp_ce   = (i % 20) < 5;
            exp_tick = (i == 19);
         end else begin
            exp_ce   = ((i - 20) % 10) < 2;
            exp_tick = ((i - 20) % 10) == 9;
         end
         exp_rdy = (i < 4) || (i >= 20);
         n_chk++;
         if (ce !== exp_ce || period_tick !== exp_tick || cfg_if.cfg_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL shadow cyc %0d: ce=%b tick=%b ready=%b expected %b %b %b",
                     i, ce, period_tick, cfg_if.cfg_ready, exp_ce, exp_tick, exp_rdy);
         end
         if (i == 3) begin
            cfg_if.cfg_valid   = 1'b1;
            cfg_if.cfg_period  = CNT_W'(9);
            cfg_if.cfg_on      = CNT_W'(1);
            cfg_if.cfg_oneshot = 1'b0;
         end
         if (i == 4) begin
            cfg_if.cfg_period = CNT_W'(29);
            cfg_if.cfg_on     = CNT_W'(29);
         end
         if (i == 8) cfg_if.cfg_valid = 1'b0;
         step();
      end
   endtask

   task automatic test_stop();
      do_reset();
      write_cfg(19, 4, 1'b0);
      pulse_start();
      for (int i = 0; i < 26; i++) begin
         n_chk++;
         if (ce !== (i < 5) || busy !== (i < 5) || period_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_in_on cyc %0d: ce=%b busy=%b tick=%b expected %b %b 0",
                     i, ce, busy, period_tick, (i < 5), (i < 5));
         end
         stop = (i == 1);
         step();
      end
      pulse_start();
      for (int i = 0; i < 14; i++) begin
         n_chk++;
         if (ce !== (i < 5) || busy !== (i < 9) || period_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_in_off cyc %0d: ce=%b busy=%b tick=%b expected %b %b 0",
                     i, ce, busy, period_tick, (i < 5), (i < 9));
         end
         stop = (i == 8);
         step();
      end
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || ce !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_priority: busy=%b ce=%b expected 0 0", busy, ce);
      end
   endtask

   task automatic test_oneshot();
      do_reset();
      write_cfg(9, 9, 1'b1);
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if (ce !== (i < 10) || busy !== (i < 10) || period_tick !== (i == 9)) begin
            n_fail++;
            $display("FAIL oneshot cyc %0d: ce=%b busy=%b tick=%b expected %b %b %b",
                     i, ce, busy, period_tick, (i < 10), (i < 10), (i == 9));
         end
         step();
      end
      write_cfg(0, 0, 1'b0);
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (ce !== 1'b1 || period_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL period0 cyc %0d: ce=%b tick=%b expected 1 1", i, ce, period_tick);
         end
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || ce !== 1'b0) begin
         n_fail++;
         $display("FAIL period0 stop: busy=%b ce=%b expected 0 0", busy, ce);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_start();
      step();
      step();
      write_cfg(19, 4, 1'b0);
      n_chk++;
      if (cfg_if.cfg_ready !== 1'b0 || ce !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid pending: ready=%b ce=%b expected 0 1", cfg_if.cfg_ready, ce);
      end
      rst_n = 1'b0;
      step();
      n_chk++;
      if (ce !== 1'b0 || busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid: ce=%b busy=%b ready=%b expected 0 0 1",
                  ce, busy, cfg_if.cfg_ready);
      end
      rst_n = 1'b1;
      pulse_start();
      for (int i = 0; i < 14; i++) begin
         n_chk++;
         if (ce !== (i < 10)) begin
            n_fail++;
            $display("FAIL reset_mid shadow discarded cyc %0d: ce=%b expected %b", i, ce, (i < 10));
         end
         step();
      end
   endtask

   initial begin
      cfg_if.cfg_valid   = 1'b0;
      cfg_if.cfg_period  = '0;
      cfg_if.cfg_on      = '0;
      cfg_if.cfg_oneshot = 1'b0;
      test_reset();
      test_default_run();
      test_cfg_idle();
      test_cfg_reject();
      test_shadow();
      test_stop();
      test_oneshot();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
